matrix_arbiter: RTL and testbench
=================================

MATRIX_ARBITER -- requirements
Module: matrix_arbiter

Interface
REQ-001 SHALL: clk_1kHz  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset; synchronous and active-low.
REQ-003 SHALL: req  in  3  write requests; bit0 cat, bit1 dog, bit2 rat.
REQ-004 SHALL: cat_col, dog_col, rat_col  in  8 each  column image per requester; held stable while matching req is high.
REQ-005 SHALL: led  in  16  game status; 16'hFFFF selects win mode.
REQ-006 SHALL: gnt  out  3  one-hot grant, one-cycle pulse per accepted write.
REQ-007 SHALL: row  out  8  active-low row select; exactly one bit low outside reset.
REQ-008 SHALL: col_r, col_g  out  8 each  active-high red/green column drive.

Function
REQ-009 SHALL: 3-bit scan counter increments every cycle and wraps 7->0; row bit cnt is the only low bit.
REQ-010 SHALL: row/col_r/col_g are registered; each reflects the buffer contents of the row selected by the counter value of the previous cycle (1-cycle latency).
REQ-011 SHALL: red and green 8x8 frame buffers; row ownership: cat -> red rows 7,6; dog -> green rows 4,3; rat -> red and green rows 1,0; rows 5,2 never written, always drive 0.
REQ-012 SHALL: at most one grant per cycle; round-robin priority starting at pointer; after granting i, pointer = (i+1) mod 3.
REQ-013 SHALL: requester granted in cycle N is masked in cycle N+1; it may be granted again no earlier than N+2.
REQ-014 SHALL: on the edge gnt[i] asserts, the requester's column byte is written into all its owned rows and planes; the display shows it from the next scan of those rows.
REQ-015 SHALL: requester keeps req and data until it samples gnt, then drops req the following cycle; req dropped before grant withdraws with no write.
REQ-016 SHALL: led==16'hFFFF (combinational compare, registered once) enters win mode: col_r=0, col_g=win pattern by row (7..0: 81,C3,C3,66,66,3C,3C,18 hex), gnt held 0, pending req waits; buffers retained.
REQ-017 SHALL: leaving win mode resumes buffer display and arbitration next cycle with pointer unchanged.
REQ-018 SHALL: all three req high with pointer 0 -> grants cat, dog, rat, cat... on consecutive cycles.

Reset
REQ-019 SHALL: with rst_n low at an edge: row=8'hFF, col_r=col_g=0, gnt=0, cnt=0, pointer=0, buffers cleared, win flag and blink phase 0.
REQ-020 SHALL: reset mid-handshake discards the pending request; no write occurs on the reset edge.

Configuration
REQ-021 SHALL: macro WIN_BLINK_EN defined -> win pattern shown 250 cycles then col_g=0 250 cycles, repeating; phase counter restarts at win entry; row scanning continues throughout.
REQ-022 SHALL: WIN_BLINK_EN undefined -> win pattern steady, no phase counter present.

Structure
REQ-023 SHALL: shared package matrix_pkg holds requester index constants, row-ownership constants, 8-entry win pattern table, BLINK_HALF=250.
REQ-024 SHALL: scan counter is a sub-module row_scan_cnt (mod-8 counter with sync active-low reset).

Verification
REQ-025 SHALL: reset released, no req -> row walks FE,FD,FB,...,7F, then FE repeating; col_r=col_g=0.
REQ-026 SHALL: req=001, cat_col=8'hA5 -> gnt=001 one cycle; subsequent scans of rows 7,6 give col_r=A5, col_g=0.
REQ-027 SHALL: req=111 held, data 11/22/33 -> gnt 001,010,100 on consecutive cycles; rows 1,0 give col_r=col_g=33; rows 4,3 give col_g=22.
REQ-028 SHALL: led=FFFF with req=010 pending -> gnt stays 0, col_g follows win table, col_r=0; led=0000 -> dog granted next cycle.
REQ-029 SHALL: rst_n low for one edge during pending req=100 -> outputs at reset values, buffers 0, no gnt, no write.
REQ-030 SHALL: WIN_BLINK_EN built, led=FFFF -> pattern 250 cycles, blank 250 cycles, pattern again at cycle 500.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants for the 8x8 LED matrix arbiter: requester indices, row ownership,
// win-mode pattern table and blink half-period.
package matrix_pkg;

    typedef enum logic [1:0] {
        REQ_CAT = 2'd0,
        REQ_DOG = 2'd1,
        REQ_RAT = 2'd2
    } req_idx_e;

    localparam int NREQ = 3;

    // Row ownership per requester (bit r set = requester owns row r in that plane)
    localparam logic [NREQ-1:0][7:0] OWN_RED = {8'h03, 8'h00, 8'hC0};
    localparam logic [NREQ-1:0][7:0] OWN_GRN = {8'h03, 8'h18, 8'h00};

    // Win pattern indexed by row number, row 7 in the most significant byte
    localparam logic [7:0][7:0] WIN_PAT = {8'h81, 8'hC3, 8'hC3, 8'h66,
                                           8'h66, 8'h3C, 8'h3C, 8'h18};

    localparam int BLINK_HALF = 250;

    function automatic logic [2:0] rot_right(input logic [2:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[0], v[2:1]};
            2'd2:    return {v[1:0], v[2]};
            default: return v;
        endcase
    endfunction

    function automatic logic [2:0] rot_left(input logic [2:0] v, input logic [1:0] n);
        case (n)
            2'd1:    return {v[1:0], v[2]};
            2'd2:    return {v[0], v[2:1]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/row_scan_cnt.sv
// Free-running mod-8 row scan counter with synchronous active-low reset.
module row_scan_cnt (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [2:0] o_cnt
);

    logic [2:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/matrix_arbiter.sv
// Round-robin write arbiter for a red/green 8x8 LED matrix with row scanning and win mode.
// Define WIN_BLINK_EN to make the win pattern blink (BLINK_HALF cycles on, BLINK_HALF off).
module matrix_arbiter
    import matrix_pkg::*;
(
    input  logic        clk_1kHz,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [7:0]  cat_col,
    input  logic [7:0]  dog_col,
    input  logic [7:0]  rat_col,
    input  logic [15:0] led,
    output logic [2:0]  gnt,
    output logic [7:0]  row,
    output logic [7:0]  col_r,
    output logic [7:0]  col_g
);

    logic [2:0]      w_cnt;
    logic            w_led_win;
    logic            w_blank;
    logic [2:0]      w_elig;
    logic [2:0]      w_rot;
    logic [2:0]      w_pick;
    logic [2:0]      w_gnt_nxt;
    logic [1:0]      w_ptr_nxt;
    logic [7:0]      w_wr_data;
    logic [7:0]      w_wr_red;
    logic [7:0]      w_wr_grn;

    logic [1:0]      r_ptr;
    logic [2:0]      r_gnt;
    logic            r_win;
    logic [7:0][7:0] r_red;
    logic [7:0][7:0] r_grn;
    logic [7:0]      r_row;
    logic [7:0]      r_col_r;
    logic [7:0]      r_col_g;

    row_scan_cnt u_scan (
        .i_clk   (clk_1kHz),
        .i_rst_n (rst_n),
        .o_cnt   (w_cnt)
    );

    assign w_led_win = (led == 16'hFFFF);

    // Last cycle's grantee is masked so a requester still holding req is not granted twice
    assign w_elig = req & ~r_gnt & {3{~r_win}};

    always_comb begin
        w_rot     = rot_right(w_elig, r_ptr);
        w_pick    = w_rot & (~w_rot + 3'd1);
        w_gnt_nxt = rot_left(w_pick, r_ptr);
        case (w_gnt_nxt)
            3'b001:  w_ptr_nxt = 2'd1;
            3'b010:  w_ptr_nxt = 2'd2;
            3'b100:  w_ptr_nxt = 2'd0;
            default: w_ptr_nxt = r_ptr;
        endcase
    end

    always_comb begin
        w_wr_data = '0;
        w_wr_red  = '0;
        w_wr_grn  = '0;
        case (w_gnt_nxt)
            3'b001: begin
                w_wr_data = cat_col;
                w_wr_red  = OWN_RED[REQ_CAT];
                w_wr_grn  = OWN_GRN[REQ_CAT];
            end
            3'b010: begin
                w_wr_data = dog_col;
                w_wr_red  = OWN_RED[REQ_DOG];
                w_wr_grn  = OWN_GRN[REQ_DOG];
            end
            3'b100: begin
                w_wr_data = rat_col;
                w_wr_red  = OWN_RED[REQ_RAT];
                w_wr_grn  = OWN_GRN[REQ_RAT];
            end
            default: begin
                w_wr_data = '0;
            end
        endcase
    end

`ifdef WIN_BLINK_EN
    logic [7:0] r_blink_cnt;
    logic       r_blink_ph;

    // Phase restarts on the edge that enters win mode so every win starts lit
    always_ff @(posedge clk_1kHz) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_led_win && !r_win) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_win) begin
            if (r_blink_cnt == 8'(BLINK_HALF - 1)) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    assign w_blank = r_blink_ph;
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk_1kHz) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_win   <= 1'b0;
            r_red   <= '0;
            r_grn   <= '0;
            r_row   <= 8'hFF;
            r_col_r <= '0;
            r_col_g <= '0;
        end else begin
            r_win <= w_led_win;
            r_gnt <= w_gnt_nxt;
            r_ptr <= w_ptr_nxt;
            for (int r = 0; r < 8; r++) begin
                if (w_wr_red[r]) r_red[r] <= w_wr_data;
                if (w_wr_grn[r]) r_grn[r] <= w_wr_data;
            end
            // Display registers read the pre-write buffer: new data appears on the next scan
            r_row <= ~(8'h01 << w_cnt);
            if (r_win) begin
                r_col_r <= '0;
                r_col_g <= w_blank ? 8'h00 : WIN_PAT[w_cnt];
            end else begin
                r_col_r <= r_red[w_cnt];
                r_col_g <= r_grn[w_cnt];
            end
        end
    end

    assign gnt   = r_gnt;
    assign row   = r_row;
    assign col_r = r_col_r;
    assign col_g = r_col_g;

endmodule

// File: tb/tb_matrix_arbiter.sv
// Scoreboard bench for matrix_arbiter: a per-requester reference model queues expected
// outputs each edge; a negedge monitor pops and compares them against the DUT.
module tb_matrix_arbiter;

    logic        clk_1kHz = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [7:0]  cat_col, dog_col, rat_col;
    logic [15:0] led;
    logic [2:0]  gnt;
    logic [7:0]  row, col_r, col_g;

    matrix_arbiter dut (
        .clk_1kHz (clk_1kHz),
        .rst_n    (rst_n),
        .req      (req),
        .cat_col  (cat_col),
        .dog_col  (dog_col),
        .rat_col  (rat_col),
        .led      (led),
        .gnt      (gnt),
        .row      (row),
        .col_r    (col_r),
        .col_g    (col_g)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    typedef struct {
        logic [7:0] row;
        logic [7:0] col_r;
        logic [7:0] col_g;
        logic [2:0] gnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // ---------------- reference model ----------------
    int         m_cnt, m_ptr, m_last, m_age, m_win, winner;
    logic [7:0] m_val [3];
    exp_t       m_e;

    function automatic logic [7:0] win_row(input int r);
        case (r)
            7: return 8'h81;
            6, 5: return 8'hC3;
            4, 3: return 8'h66;
            2, 1: return 8'h3C;
            default: return 8'h18;
        endcase
    endfunction

    function automatic logic [7:0] col_of(input int i);
        case (i)
            0: return cat_col;
            1: return dog_col;
            default: return rat_col;
        endcase
    endfunction

    always @(posedge clk_1kHz) begin
        cyc++;
        if (!rst_n) begin
            m_e    = '{row: 8'hFF, col_r: 8'h00, col_g: 8'h00, gnt: 3'b000};
            m_cnt  = 0;
            m_ptr  = 0;
            m_last = -1;
            m_age  = 0;
            m_win  = 0;
            for (int i = 0; i < 3; i++) m_val[i] = 8'h00;
        end else begin
            m_e.row = ~(8'h01 << m_cnt);
            if (m_win != 0) begin
                m_e.col_r = 8'h00;
                m_e.col_g = win_row(m_cnt);
`ifdef WIN_BLINK_EN
                if (((m_age / 250) % 2) == 1) m_e.col_g = 8'h00;
`endif
                m_age++;
            end else begin
                m_e.col_r = (m_cnt >= 6) ? m_val[0] : (m_cnt <= 1) ? m_val[2] : 8'h00;
                m_e.col_g = (m_cnt == 3 || m_cnt == 4) ? m_val[1] : (m_cnt <= 1) ? m_val[2] : 8'h00;
            end
            m_e.gnt = 3'b000;
            winner  = -1;
            if (m_win == 0) begin
                for (int k = 0; k < 3; k++) begin
                    int j;
                    j = (m_ptr + k) % 3;
                    if (winner < 0 && req[j] && j != m_last) winner = j;
                end
            end
            if (winner >= 0) begin
                m_e.gnt[winner] = 1'b1;
                m_val[winner]   = col_of(winner);
                m_ptr           = (winner + 1) % 3;
            end
            m_last = winner;
            m_cnt  = (m_cnt + 1) % 8;
            if (m_win == 0 && led == 16'hFFFF) m_age = 0;
            m_win = (led == 16'hFFFF) ? 1 : 0;
        end
        exp_q.push_back(m_e);
    end

    // ---------------- monitor ----------------
    logic [2:0] gnt_seen = 3'b000;
    exp_t       mon_e;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clk_1kHz) begin
        gnt_seen = gnt;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("row", row, mon_e.row);
            check("col_r", col_r, mon_e.col_r);
            check("col_g", col_g, mon_e.col_g);
            check("gnt", {5'b0, gnt}, {5'b0, mon_e.gnt});
        end
    end

    // ---------------- requesters / stimulus ----------------
    logic [2:0] pend;
    logic [2:0] hold;
    logic [7:0] data [3];
    bit         auto_mode = 0;
    bit         win_on    = 0;

    task automatic apply();
        req     = pend;
        cat_col = data[0];
        dog_col = data[1];
        rat_col = data[2];
    endtask

    task automatic tick();
        @(posedge clk_1kHz);
        #1;
        for (int i = 0; i < 3; i++) begin
            hold[i] = gnt_seen[i];
            if (gnt_seen[i]) pend[i] = 1'b0;
        end
        if (auto_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && !hold[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    data[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 99) == 0) win_on = !win_on;
            led = win_on ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
        end
        apply();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        led   = 16'h0000;
        pend  = 3'b000;
        hold  = 3'b000;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;
        apply();
        run(3);
        rst_n = 1'b1;
        run(20);

        // single cat write
        pend[0] = 1'b1; data[0] = 8'hA5; apply();
        run(20);

        // all three contend
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        pend = 3'b111; apply();
        run(20);

        // win mode with dog pending, then release
        led = 16'hFFFF;
        run(1);
        pend[1] = 1'b1; data[1] = 8'h44; apply();
        run(20);
        led = 16'h0000;
        run(12);

        // reset during a pending rat request
        pend[2] = 1'b1; data[2] = 8'h55; rst_n = 1'b0; apply();
        @(posedge clk_1kHz);
        #1;
        rst_n = 1'b1; pend = 3'b000; apply();
        run(12);

`ifdef WIN_BLINK_EN
        led = 16'hFFFF;
        run(1100);
        led = 16'h0000;
        run(10);
`endif

        // randomized traffic
        auto_mode = 1;
        run(3000);
        auto_mode = 0;
        led  = 16'h0000;
        pend = 3'b000; apply();
        run(5);

        @(negedge clk_1kHz);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain at cycle %0d: got %0d queued, expected 0", cyc, exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
